// File: rtl/spi_master_ctrl_if.sv
// Bus bundle between the SPI master sequencer and the master/slave selection logic.
// The master modport is the sequencer's view; slave is the consumer's view.
`timescale 1ns/1ps
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
);
  localparam int BW = $clog2(DATA_W + 1);

  logic             MSTR;
  logic             start;
  logic [DIV_W-1:0] baud_div;
  logic             CPOL;
  logic             CPHA;
  logic             SCK;
  logic             SS_n;
  logic             load;
  logic             M_Shift_clk;
  logic             M_Sample_clk;
  logic             BaudRate;
  logic             idle;
  logic             done;
  logic [BW-1:0]    bit_cnt;

  modport master (
    input  MSTR, start, baud_div, CPOL, CPHA,
    output SCK, SS_n, load, M_Shift_clk, M_Sample_clk, BaudRate, idle, done, bit_cnt
  );

  modport slave (
    output MSTR, start, baud_div, CPOL, CPHA,
    input  SCK, SS_n, load, M_Shift_clk, M_Sample_clk, BaudRate, idle, done, bit_cnt
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master transfer sequencer: slave select, SCK generation from a baud divider,
// and registered one-cycle load/shift/sample strobes for the shared shift register.
`timescale 1ns/1ps
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.master bus
);
  localparam int            BW        = $clog2(DATA_W + 1);
  localparam int            EW        = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             cpol_q, cpol_d, cpha_q, cpha_d;
  logic             sck_q, sck_d, ss_n_q, ss_n_d, load_q, load_d;
  logic             shift_q, shift_d, sample_q, sample_d;
  logic             baud_q, baud_d, done_q, done_d;
  logic             tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    edge_d    = edge_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    bit_cnt_d = bit_cnt_q + BW'(sample_q);
    sck_d     = sck_q;
    ss_n_d    = ss_n_q;
    load_d    = 1'b0;
    shift_d   = 1'b0;
    sample_d  = 1'b0;
    baud_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        sck_d  = bus.CPOL;
        if (bus.start && bus.MSTR) begin
          state_d   = LEAD;
          load_d    = 1'b1;
          ss_n_d    = 1'b0;
          bit_cnt_d = '0;
          edge_d    = '0;
          cnt_d     = bus.baud_div;
          div_d     = bus.baud_div;
          cpol_d    = bus.CPOL;
          cpha_d    = bus.CPHA;
        end
      end
      LEAD, XFER: begin
        if (tick) begin
          // The LEAD half-period ends by launching edge 1; XFER launches the rest.
          cnt_d  = div_q;
          edge_d = edge_q + EW'(1);
          sck_d  = ~sck_q;
          baud_d = 1'b1;
          if (edge_d[0]) begin
            shift_d  = cpha_q;
            sample_d = ~cpha_q;
          end else begin
            sample_d = cpha_q;
            shift_d  = ~cpha_q && (edge_d != LAST_EDGE);
          end
          state_d = (edge_d == LAST_EDGE) ? TRAIL : XFER;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d = IDLE;
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing master mode overrides everything the sequencer decided this cycle.
    if (state_q != IDLE && !bus.MSTR) begin
      state_d  = IDLE;
      ss_n_d   = 1'b1;
      sck_d    = cpol_q;
      cnt_d    = '0;
      shift_d  = 1'b0;
      sample_d = 1'b0;
      baud_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      edge_q    <= '0;
      bit_cnt_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sck_q     <= 1'b0;
      ss_n_q    <= 1'b1;
      load_q    <= 1'b0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
      baud_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      bit_cnt_q <= bit_cnt_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sck_q     <= sck_d;
      ss_n_q    <= ss_n_d;
      load_q    <= load_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      baud_q    <= baud_d;
      done_q    <= done_d;
    end
  end

  assign bus.SCK          = sck_q;
  assign bus.SS_n         = ss_n_q;
  assign bus.load         = load_q;
  assign bus.M_Shift_clk  = shift_q;
  assign bus.M_Sample_clk = sample_q;
  assign bus.BaudRate     = baud_q;
  assign bus.idle         = (state_q == IDLE);
  assign bus.done         = done_q;
  assign bus.bit_cnt      = bit_cnt_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a timing-formula model fills a scoreboard
// queue at each start; every mid-cycle sample pops and compares one expected record.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int BW = $clog2(N + 1);

  typedef struct packed {
    logic          sck;
    logic          ss_n;
    logic          load;
    logic          shift;
    logic          sample;
    logic          baud;
    logic          idle;
    logic          done;
    logic [BW-1:0] bit_cnt;
    logic          chk_bc;
  } exp_t;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    int         exp_done;
    int         exp_shifts;
    int         exp_samples;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_W(N), .DIV_W(DW)) bus ();
  spi_master_ctrl #(.DATA_W(N), .DIV_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc_n, got, want);
    end
  endtask

  // Expected outputs in cycle c (1 = load cycle) of a transfer with half-period h.
  function automatic exp_t model(int c, int h, logic cpol, logic cpha);
    exp_t e;
    int   d, edges, k, samples;
    d = (2 * N + 1) * h + 1;
    e = '0;
    e.chk_bc = 1'b1;
    edges = (c - 1) / h;
    if (edges > 2 * N) edges = 2 * N;
    e.sck  = cpol ^ edges[0];
    e.ss_n = (c == d);
    e.idle = (c == d);
    e.done = (c == d);
    e.load = (c == 1);
    if (c > 1 && (c - 1) % h == 0 && (c - 1) / h <= 2 * N) begin
      k = (c - 1) / h;
      e.baud = 1'b1;
      if (k % 2 == 1) begin
        e.shift  = cpha;
        e.sample = ~cpha;
      end else begin
        e.sample = cpha;
        e.shift  = ~cpha && (k != 2 * N);
      end
    end
    samples = 0;
    for (int j = 1; j <= 2 * N; j++)
      if (1 + j * h <= c - 1 && ((j % 2 == 1) ^ cpha)) samples++;
    e.bit_cnt = BW'(samples);
    return e;
  endfunction

  function automatic exp_t idle_rec(logic sck, logic chk_bc);
    exp_t e;
    e = '0;
    e.sck    = sck;
    e.ss_n   = 1'b1;
    e.idle   = 1'b1;
    e.chk_bc = chk_bc;
    return e;
  endfunction

  function automatic int xfer_len(int h);
    return (2 * N + 1) * h + 1;
  endfunction

  task automatic push_xfer(int first, int last, int h, logic cpol, logic cpha);
    for (int c = first; c <= last; c++) sb_q.push_back(model(c, h, cpol, cpha));
  endtask

  // Advance to mid-cycle of the next clock period and score one expected record.
  task automatic cyc();
    exp_t e, a;
    @(negedge clk);
    cyc_n++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a.sck     = bus.SCK;
      a.ss_n    = bus.SS_n;
      a.load    = bus.load;
      a.shift   = bus.M_Shift_clk;
      a.sample  = bus.M_Sample_clk;
      a.baud    = bus.BaudRate;
      a.idle    = bus.idle;
      a.done    = bus.done;
      a.bit_cnt = e.chk_bc ? bus.bit_cnt : e.bit_cnt;
      a.chk_bc  = e.chk_bc;
      check("sb", 32'(a), 32'(e));
    end
  endtask

  task automatic start_xfer(logic cpol, logic cpha, logic [7:0] div);
    bus.CPOL     = cpol;
    bus.CPHA     = cpha;
    bus.baud_div = div;
    bus.MSTR     = 1'b1;
    bus.start    = 1'b1;
  endtask

  task automatic run_xfer(input vec_t v, output int done_c, output int sh, output int sa);
    int h;
    h = int'(v.div) + 1;
    done_c = -1;
    sh = 0;
    sa = 0;
    start_xfer(v.cpol, v.cpha, v.div);
    push_xfer(1, xfer_len(h), h, v.cpol, v.cpha);
    for (int c = 1; c <= xfer_len(h); c++) begin
      cyc();
      if (c == 1) bus.start = 1'b0;
      if (bus.M_Shift_clk) sh++;
      if (bus.M_Sample_clk) sa++;
      if (bus.done && done_c < 0) done_c = c;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   done_c, sh, sa, loads, dones, h;

    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, div: 8'd0, exp_done: 18, exp_shifts: 7, exp_samples: 8};
    vecs[1] = '{cpol: 1'b1, cpha: 1'b1, div: 8'd1, exp_done: 35, exp_shifts: 8, exp_samples: 8};
    vecs[2] = '{cpol: 1'b0, cpha: 1'b1, div: 8'd2, exp_done: 52, exp_shifts: 8, exp_samples: 8};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b0, div: 8'd3, exp_done: 69, exp_shifts: 7, exp_samples: 8};

    // Reset with CPOL=1 so a reset SCK of 0 is distinguishable from the idle level.
    rst_n        = 1'b0;
    bus.MSTR     = 1'b0;
    bus.start    = 1'b0;
    bus.baud_div = '0;
    bus.CPOL     = 1'b1;
    bus.CPHA     = 1'b0;
    cyc();
    sb_q.push_back(idle_rec(1'b0, 1'b1));
    cyc();
    sb_q.push_back(idle_rec(1'b0, 1'b1));
    cyc();
    rst_n    = 1'b1;
    bus.CPOL = 1'b0;
    cyc();

    foreach (vecs[i]) begin
      run_xfer(vecs[i], done_c, sh, sa);
      check($sformatf("done_cyc%0d", i), done_c, vecs[i].exp_done);
      check($sformatf("shifts%0d", i), sh, vecs[i].exp_shifts);
      check($sformatf("samples%0d", i), sa, vecs[i].exp_samples);
    end

    // Config inputs scrambled mid-transfer must not disturb the latched mode.
    h = 2;
    sh = 0;
    start_xfer(1'b0, 1'b0, 8'd1);
    push_xfer(1, xfer_len(h), h, 1'b0, 1'b0);
    for (int c = 1; c <= xfer_len(h); c++) begin
      cyc();
      if (bus.M_Shift_clk) sh++;
      if (c == 1) bus.start = 1'b0;
      if (c == 8) begin
        bus.baud_div = 8'd5;
        bus.CPHA     = 1'b1;
      end
      if (c == 30) begin
        bus.baud_div = 8'd1;
        bus.CPHA     = 1'b0;
      end
    end
    check("midchg_shifts", sh, 7);

    // Abort: MSTR low during cycle 6, block idle from cycle 7 with nothing further.
    start_xfer(1'b0, 1'b0, 8'd0);
    push_xfer(1, 6, 1, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) bus.start = 1'b0;
    end
    bus.MSTR = 1'b0;
    for (int c = 7; c <= 12; c++) begin
      sb_q.push_back(idle_rec(1'b0, 1'b0));
      cyc();
    end
    bus.MSTR = 1'b1;

    // start held high: three back-to-back transfers, each done cycle is the IDLE cycle.
    loads = 0;
    dones = 0;
    start_xfer(1'b0, 1'b0, 8'd0);
    for (int t = 0; t < 3; t++) begin
      push_xfer(1, xfer_len(1), 1, 1'b0, 1'b0);
      for (int c = 1; c <= xfer_len(1); c++) begin
        cyc();
        if (bus.load) loads++;
        if (bus.done) dones++;
      end
    end
    bus.start = 1'b0;
    sb_q.push_back(idle_rec(1'b0, 1'b1));
    sb_q[0].bit_cnt = BW'(N);
    cyc();
    check("held_loads", loads, 3);
    check("held_dones", dones, 3);

    // Reset asserted during cycle 9 of a transfer; reset values from cycle 10.
    start_xfer(1'b0, 1'b0, 8'd0);
    push_xfer(1, 9, 1, 1'b0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    sb_q.push_back(idle_rec(1'b0, 1'b1));
    cyc();
    rst_n     = 1'b1;
    bus.MSTR  = 1'b0;
    bus.start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sb_q.push_back(idle_rec(1'b0, 1'b1));
      cyc();
    end
    bus.start = 1'b0;

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
